poly_compress_pack: RTL and testbench

Downstream consumer of the polynomial serializer in the Kyber-512 datapath. Drives the serializer's 8-bit coefficient index and takes back one 16-bit coefficient per fetch. Applies Kyber Compress_q(x, D) to each coefficient and bit-packs the 256 D-bit results little-endian into an 8-bit byte stream under valid/ready handshake. One start produces exactly 32*D bytes.

---
 rtl/poly_compress_pack.sv | 126 ++++++++++++
 tb/tb_poly_compress_pack.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/poly_compress_pack.sv
// poly_compress_pack: Kyber Compress_q(x, D) over 256 serializer coefficients,
// bit-packed little-endian (ByteEncode_D order) into a valid/ready byte stream.
// One start yields exactly 32*D bytes.
// Optional: define POLY_PACK_RANGE_CHECK_EN to add a sticky coef_err output
// flagging coefficients >= 2Q.
module poly_compress_pack #(
   parameter int D = 10,
   parameter int Q = 3329
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   output logic [7:0]  coef_idx,
   input  logic [15:0] coef_in,
   output logic [7:0]  byte_out,
   output logic        byte_valid,
   input  logic        byte_ready,
   output logic        busy,
   output logic        done
`ifdef POLY_PACK_RANGE_CHECK_EN
   ,
   output logic        coef_err
`endif
);

   // 7 carried bits plus up to 11 new bits
   localparam int AW = 18;
   localparam int NW = 12 + D;

   typedef enum logic [2:0] {S_IDLE, S_ADDR, S_CAPT, S_EMIT, S_DONE} state_t;

   state_t          state_q, state_d;
   logic [7:0]      n_q, n_d;
   logic [AW-1:0]   acc_q, acc_d;
   logic [4:0]      cnt_q, cnt_d;
   logic [11:0]     x;
   logic [NW-1:0]   num;
   logic [D-1:0]    c;
`ifdef POLY_PACK_RANGE_CHECK_EN
   logic            err_q, err_d;
`endif

   // Compress: one conditional subtract, then exact rounding division by Q.
   // Truncation to D bits implements the mod 2^D wrap for x near Q.
   always_comb begin
      x   = (coef_in >= 16'(Q)) ? 12'(coef_in - 16'(Q)) : coef_in[11:0];
      num = (NW'(x) << D) + NW'(Q / 2);
      c   = D'(num / NW'(Q));
   end

   // Next-state: fetch, compress/append, drain whole bytes, advance.
   always_comb begin
      state_d = state_q;
      n_d     = n_q;
      acc_d   = acc_q;
      cnt_d   = cnt_q;
      case (state_q)
         S_IDLE: if (start) begin
            n_d     = '0;
            acc_d   = '0;
            cnt_d   = '0;
            state_d = S_ADDR;
         end
         S_ADDR: state_d = S_CAPT;
         S_CAPT: begin
            acc_d   = acc_q | (AW'(c) << cnt_q);
            cnt_d   = cnt_q + 5'(D);
            state_d = S_EMIT;
         end
         S_EMIT: begin
            if (cnt_q >= 5'd8) begin
               if (byte_ready) begin
                  acc_d = acc_q >> 8;
                  cnt_d = cnt_q - 5'd8;
               end
            end else if (n_q == 8'd255) begin
               state_d = S_DONE;
            end else begin
               n_d     = n_q + 8'd1;
               state_d = S_ADDR;
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

`ifdef POLY_PACK_RANGE_CHECK_EN
   // Sticky range flag, cleared by an accepted start.
   always_comb begin
      err_d = err_q;
      if (state_q == S_IDLE && start) err_d = 1'b0;
      if (state_q == S_CAPT && coef_in >= 16'(2 * Q)) err_d = 1'b1;
   end
   assign coef_err = err_q;
`endif

   // State registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_IDLE;
         n_q     <= '0;
         acc_q   <= '0;
         cnt_q   <= '0;
`ifdef POLY_PACK_RANGE_CHECK_EN
         err_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         n_q     <= n_d;
         acc_q   <= acc_d;
         cnt_q   <= cnt_d;
`ifdef POLY_PACK_RANGE_CHECK_EN
         err_q   <= err_d;
`endif
      end
   end

   // Outputs decode from registered state only, so they hold during stalls.
   assign coef_idx   = n_q;
   assign byte_out   = acc_q[7:0];
   assign byte_valid = (state_q == S_EMIT) && (cnt_q >= 5'd8);
   assign busy       = (state_q == S_ADDR) || (state_q == S_CAPT) || (state_q == S_EMIT);
   assign done       = (state_q == S_DONE);

endmodule

// File: tb/tb_poly_compress_pack.sv
// Bench for poly_compress_pack: D=10 and D=4 instances run side by side from a
// shared registered coefficient memory; streams are checked against a
// bit-level ByteEncode model of Compress_q.
module tb_poly_compress_pack;
   localparam int Q = 3329;

   logic        clk = 1'b0;
   logic        reset, start, byte_ready;
   logic [15:0] mem [256];
   logic [7:0]  idx10, idx4, bo10, bo4;
   logic [15:0] cin10, cin4;
   logic        bv10, bv4, busy10, busy4, done10, done4;
`ifdef POLY_PACK_RANGE_CHECK_EN
   logic        err10, err4;
`endif

   logic [7:0]  q10[$];
   logic [7:0]  q4[$];
   int          done10_n = 0, done4_n = 0, done10_bytes = 0, done4_bytes = 0;
   int          checks = 0, errors = 0;

   poly_compress_pack #(.D(10), .Q(Q)) u10 (
      .clk(clk), .reset(reset), .start(start), .coef_idx(idx10), .coef_in(cin10),
      .byte_out(bo10), .byte_valid(bv10), .byte_ready(byte_ready), .busy(busy10), .done(done10)
`ifdef POLY_PACK_RANGE_CHECK_EN
      , .coef_err(err10)
`endif
   );

   poly_compress_pack #(.D(4), .Q(Q)) u4 (
      .clk(clk), .reset(reset), .start(start), .coef_idx(idx4), .coef_in(cin4),
      .byte_out(bo4), .byte_valid(bv4), .byte_ready(byte_ready), .busy(busy4), .done(done4)
`ifdef POLY_PACK_RANGE_CHECK_EN
      , .coef_err(err4)
`endif
   );

   always #5 clk = ~clk;

   // serializer stand-in: registered read
   always @(posedge clk) begin
      cin10 <= mem[idx10];
      cin4  <= mem[idx4];
   end

   // collect accepted bytes and done pulses mid-cycle
   always @(negedge clk) begin
      if (!reset && bv10 && byte_ready) q10.push_back(bo10);
      if (!reset && bv4 && byte_ready) q4.push_back(bo4);
      if (done10) begin done10_n++; done10_bytes = q10.size(); end
      if (done4) begin done4_n++; done4_bytes = q4.size(); end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic int comp(int v, int d);
      int x;
      longint num;
      x   = (v >= Q) ? v - Q : v;
      num = (longint'(x) * (64'd1 << d)) + Q / 2;
      return int'((num / Q) % (64'd1 << d));
   endfunction

   // byte k of ByteEncode_d(Compress(mem, d))
   function automatic logic [7:0] exp_byte(int d, int k);
      logic [7:0] r;
      int g, cv;
      r = '0;
      for (int b = 0; b < 8; b++) begin
         g  = 8 * k + b;
         cv = comp(int'(mem[g / d]), d);
         r[b] = cv[g % d];
      end
      return r;
   endfunction

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_bv"},   {bv10, bv4}, 2'b00);
      chk({tag, "_busy"}, {busy10, busy4}, 2'b00);
      chk({tag, "_done"}, {done10, done4}, 2'b00);
      chk({tag, "_idx"},  {idx10, idx4}, 16'h0);
      chk({tag, "_byte"}, {bo10, bo4}, 16'h0);
   endtask

   task automatic run(input bit do_stall, input int abort_at);
      int b10, b4, d10, d4, cyc, bad10, bad4;
      bit stalled;
      logic [7:0] hb, hi;
      b10 = q10.size(); b4 = q4.size(); d10 = done10_n; d4 = done4_n;
      cyc = 0; stalled = 0;
      start = 1'b1;
      @(posedge clk); #2;
      start = 1'b0;
      chk("busy_after_start", busy10, 1'b1);
      while (!(done10_n > d10 && done4_n > d4) && cyc < 5000) begin
         @(posedge clk); #2;
         cyc++;
         if (abort_at > 0 && q10.size() - b10 >= abort_at) begin
            reset = 1'b1;
            @(posedge clk); #2;
            chk_reset_vals("midpass_reset");
            reset = 1'b0;
            @(posedge clk); #2;
            chk("reset_stays_idle", busy10, 1'b0);
            return;
         end
         if (do_stall && !stalled && q10.size() - b10 == 3 && bv10) begin
            stalled = 1;
            hb = bo10; hi = idx10;
            byte_ready = 1'b0;
            repeat (5) begin
               @(posedge clk); #2;
               chk("stall_byte_hold", bo10, hb);
               chk("stall_valid_hold", bv10, 1'b1);
               chk("stall_idx_frozen", idx10, hi);
            end
            byte_ready = 1'b1;
         end
      end
      chk("pass_timeout", cyc < 5000, 1'b1);
      if (do_stall) chk("stall_happened", stalled, 1'b1);
      chk("len_d10", q10.size() - b10, 320);
      chk("len_d4",  q4.size() - b4, 128);
      chk("done_once_d10", done10_n - d10, 1);
      chk("done_once_d4",  done4_n - d4, 1);
      chk("done_after_last_d10", done10_bytes - b10, 320);
      chk("done_after_last_d4",  done4_bytes - b4, 128);
      bad10 = 0; bad4 = 0;
      for (int k = 0; k < 320 && b10 + k < q10.size(); k++)
         if (q10[b10 + k] !== exp_byte(10, k)) begin
            if (bad10 == 0) $display("FAIL stream_d10 byte %0d got 0x%0h expected 0x%0h",
                                     k, q10[b10 + k], exp_byte(10, k));
            bad10++;
         end
      for (int k = 0; k < 128 && b4 + k < q4.size(); k++)
         if (q4[b4 + k] !== exp_byte(4, k)) begin
            if (bad4 == 0) $display("FAIL stream_d4 byte %0d got 0x%0h expected 0x%0h",
                                    k, q4[b4 + k], exp_byte(4, k));
            bad4++;
         end
      chk("stream_d10_bad_bytes", bad10, 0);
      chk("stream_d4_bad_bytes", bad4, 0);
      repeat (2) @(posedge clk);
      #2;
      chk("idle_after_done", {busy10, busy4, done10, done4}, 4'b0000);
   endtask

   typedef struct {
      int         c0, c1;
      logic [7:0] b0_10, b1_10, b0_4;
   } vec_t;

   initial begin
      vec_t vt[5];
      int base10, base4;
      vt[0] = '{0,    0,   8'h00, 8'h00, 8'h00};
      vt[1] = '{1665, 2,   8'h00, 8'h06, 8'h08};
      vt[2] = '{4994, 2,   8'h00, 8'h06, 8'h08};
      vt[3] = '{3328, 1,   8'h00, 8'h00, 8'h00};
      vt[4] = '{1664, 832, 8'h00, 8'h02, 8'h48};

      reset = 1'b1; start = 1'b0; byte_ready = 1'b1;
      for (int i = 0; i < 256; i++) mem[i] = '0;
      repeat (3) @(posedge clk);
      #2;
      chk_reset_vals("init_reset");
      reset = 1'b0;
      @(posedge clk); #2;

      for (int v = 0; v < 5; v++) begin
         for (int i = 0; i < 256; i++) mem[i] = '0;
         mem[0] = 16'(vt[v].c0);
         mem[1] = 16'(vt[v].c1);
         base10 = q10.size(); base4 = q4.size();
         run(0, 0);
         chk($sformatf("vec%0d_b0_d10", v), q10[base10],     vt[v].b0_10);
         chk($sformatf("vec%0d_b1_d10", v), q10[base10 + 1], vt[v].b1_10);
         chk($sformatf("vec%0d_b0_d4", v),  q4[base4],       vt[v].b0_4);
      end

      // stall on byte 3
      for (int i = 0; i < 256; i++) mem[i] = 16'($urandom_range(0, 2 * Q - 1));
      run(1, 0);

      // random passes, including extreme values
      for (int r = 0; r < 3; r++) begin
         for (int i = 0; i < 256; i++) begin
            case ($urandom_range(0, 5))
               0:       mem[i] = 16'(Q - 1);
               1:       mem[i] = 16'(2 * Q - 1);
               2:       mem[i] = 16'(Q);
               default: mem[i] = 16'($urandom_range(0, 2 * Q - 1));
            endcase
         end
         run(0, 0);
      end

      // reset after 100 bytes, then a full clean pass
      for (int i = 0; i < 256; i++) mem[i] = 16'($urandom_range(0, 2 * Q - 1));
      run(0, 100);
      run(0, 0);

`ifdef POLY_PACK_RANGE_CHECK_EN
      for (int i = 0; i < 256; i++) mem[i] = '0;
      mem[5] = 16'(2 * Q);
      run(0, 0);
      chk("coef_err_set", {err10, err4}, 2'b11);
      repeat (4) @(posedge clk);
      #2;
      chk("coef_err_sticky", {err10, err4}, 2'b11);
      mem[5] = '0;
      start = 1'b1;
      @(posedge clk); #2;
      start = 1'b0;
      chk("coef_err_cleared", {err10, err4}, 2'b00);
      reset = 1'b1;
      @(posedge clk); #2;
      reset = 1'b0;
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
